// File: rtl/cam_table_ctrl.sv
// Command sequencer for the CAM: turns lookup/insert/delete commands into
// compare and write sequences, owns the free-slot bitmap and answers each command.
module cam_table_ctrl #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned SLICE_WIDTH   = 4,
  parameter int unsigned MATCH_LATENCY = 2,
  localparam int unsigned SLICE_COUNT  = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [SLICE_COUNT-1:0]  cmd_mask,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_hit,
  output logic [ADDR_WIDTH-1:0]   rsp_addr,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH:0]     occupancy,
  output logic [ADDR_WIDTH-1:0]   cam_write_addr,
  output logic [DATA_WIDTH-1:0]   cam_write_data,
  output logic                    cam_write_delete,
  output logic                    cam_write_enable,
  output logic [SLICE_COUNT-1:0]  cam_select_mask,
  input  logic                    cam_write_busy,
  output logic [DATA_WIDTH-1:0]   cam_compare_data,
  input  logic                    cam_match,
  input  logic [ADDR_WIDTH-1:0]   cam_match_addr,
  input  logic                    cam_setup
);

  localparam int unsigned N  = 1 << ADDR_WIDTH;
  localparam int unsigned OW = ADDR_WIDTH + 1;
  localparam int unsigned CW = 4;

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEARCH    = 3'd1,
    WRITE     = 3'd2,
    WAIT_BUSY = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t                  state;
  logic [1:0]              op_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [SLICE_COUNT-1:0]  mask_q;
  logic [CW-1:0]           lat_cnt;
  logic [N-1:0]            bitmap;
  logic [ADDR_WIDTH-1:0]   target;
  logic                    wait_first;
  logic [ADDR_WIDTH-1:0]   free_idx_c;
  logic                    full_c;

  // Lowest clear bitmap index; scanning downward lets the lowest index win.
  always_comb begin
    free_idx_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!bitmap[i]) free_idx_c = ADDR_WIDTH'(i);
    end
  end

  assign full_c = (occupancy == OW'(N));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      op_q             <= '0;
      data_q           <= '0;
      mask_q           <= '0;
      lat_cnt          <= '0;
      bitmap           <= '0;
      target           <= '0;
      wait_first       <= 1'b0;
      cmd_ready        <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_hit          <= 1'b0;
      rsp_addr         <= '0;
      rsp_err          <= 1'b0;
      occupancy        <= '0;
      cam_write_addr   <= '0;
      cam_write_data   <= '0;
      cam_write_delete <= 1'b0;
      cam_write_enable <= 1'b0;
      cam_select_mask  <= '0;
      cam_compare_data <= '0;
    end else begin
      cam_write_enable <= 1'b0;
      cam_write_delete <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            mask_q    <= cmd_mask;
            if (cmd_op == OP_RSVD) begin
              rsp_hit   <= 1'b0;
              rsp_addr  <= '0;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              cam_compare_data <= cmd_data;
              lat_cnt          <= CW'(MATCH_LATENCY);
              state            <= SEARCH;
            end
          end else begin
            cmd_ready <= !cam_setup && !cam_write_busy;
          end
        end

        SEARCH: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CW'(1);
          end else begin
            // Default outcome is an immediate response; write paths override it.
            rsp_hit   <= 1'b0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
            case (op_q)
              OP_LOOKUP: begin
                rsp_hit  <= cam_match;
                rsp_addr <= cam_match ? cam_match_addr : '0;
              end
              OP_INSERT: begin
                if (cam_match) begin
                  rsp_hit  <= 1'b1;
                  rsp_addr <= cam_match_addr;
                end else if (full_c) begin
                  rsp_err <= 1'b1;
                end else begin
                  target    <= free_idx_c;
                  rsp_addr  <= free_idx_c;
                  rsp_valid <= 1'b0;
                  state     <= WRITE;
                end
              end
              default: begin
                if (cam_match) begin
                  target    <= cam_match_addr;
                  rsp_hit   <= 1'b1;
                  rsp_addr  <= cam_match_addr;
                  rsp_valid <= 1'b0;
                  state     <= WRITE;
                end else begin
                  rsp_err <= 1'b1;
                end
              end
            endcase
          end
        end

        WRITE: begin
          if (!cam_write_busy) begin
            cam_write_enable <= 1'b1;
            cam_write_delete <= (op_q == OP_DELETE);
            cam_write_addr   <= target;
            cam_write_data   <= data_q;
            cam_select_mask  <= mask_q;
            bitmap[target]   <= (op_q != OP_DELETE);
            occupancy        <= (op_q == OP_DELETE) ? occupancy - OW'(1) : occupancy + OW'(1);
            wait_first       <= 1'b1;
            state            <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          // First cycle is skipped so the CAM's busy flag has time to assert.
          wait_first <= 1'b0;
          if (!wait_first && !cam_write_busy) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_table_ctrl.sv
// Randomized self-checking bench for cam_table_ctrl with a behavioural CAM
// and a slot-table reference model.
module tb_cam_table_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned SC = 16;
  localparam int unsigned NE = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [SC-1:0] cmd_mask;
  logic          rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [AW-1:0] rsp_addr;
  logic [AW:0]   occupancy;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_delete, cam_write_enable;
  logic [SC-1:0] cam_select_mask;
  logic          cam_write_busy;
  logic [DW-1:0] cam_compare_data;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;
  logic          cam_setup;

  int errors = 0;
  int checks = 0;

  cam_table_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err), .occupancy(occupancy),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_select_mask(cam_select_mask), .cam_write_busy(cam_write_busy),
    .cam_compare_data(cam_compare_data), .cam_match(cam_match),
    .cam_match_addr(cam_match_addr), .cam_setup(cam_setup)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: two-stage match pipeline, programmable busy after each write.
  logic [DW-1:0] cam_keys [NE];
  logic          cam_vld  [NE];
  logic          cm_hit, mp0, mp1;
  logic [AW-1:0] cm_addr, ma0, ma1;
  int            busy_cnt;
  int            busy_len = 0;
  int            pulses = 0;
  logic [AW-1:0] pulse_addr;
  logic          pulse_del;

  always_comb begin
    cm_hit  = 1'b0;
    cm_addr = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (cam_vld[i] && cam_keys[i] == cam_compare_data) begin
        cm_hit  = 1'b1;
        cm_addr = AW'(i);
      end
    end
  end

  assign cam_match      = mp1;
  assign cam_match_addr = ma1;
  assign cam_write_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) cam_vld[i] <= 1'b0;
      busy_cnt <= 0;
      mp0 <= 1'b0; mp1 <= 1'b0; ma0 <= '0; ma1 <= '0;
    end else begin
      if (cam_write_enable) begin
        cam_keys[cam_write_addr] <= cam_write_data;
        cam_vld[cam_write_addr]  <= !cam_write_delete;
        busy_cnt   <= busy_len;
        pulses     <= pulses + 1;
        pulse_addr <= cam_write_addr;
        pulse_del  <= cam_write_delete;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
      mp0 <= cm_hit; ma0 <= cm_addr;
      mp1 <= mp0;    ma1 <= ma0;
    end
  end

  // Reference model: slot table holding which key lives at which address.
  logic [DW-1:0] m_key  [NE];
  bit            m_used [NE];

  function automatic int m_find(input logic [DW-1:0] key);
    for (int i = 0; i < NE; i++) if (m_used[i] && m_key[i] == key) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NE; i++) if (m_used[i]) c++;
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NE; i++) m_used[i] = 0;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] key, input int rdy_delay,
                        output logic hit, output logic [AW-1:0] addr, output logic err,
                        output bit ok, output bit stable);
    int n;
    ok = 1; stable = 1;
    cmd_op = op; cmd_data = key; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) ok = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (!rsp_valid) ok = 0;
    hit = rsp_hit; addr = rsp_addr; err = rsp_err;
    for (int d = 0; d < rdy_delay; d++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_hit !== hit || rsp_addr !== addr || rsp_err !== err) stable = 0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] key, input int rdy_delay);
    int idx, j, p0;
    logic ehit, eerr, edel, hit, err;
    logic [AW-1:0] eaddr, addr;
    int epulse;
    bit ok, stable;
    idx = m_find(key);
    ehit = 0; eerr = 0; eaddr = '0; epulse = 0; edel = 0;
    case (op)
      2'b00: begin ehit = (idx >= 0); eaddr = (idx >= 0) ? AW'(idx) : '0; end
      2'b01: begin
        if (idx >= 0) begin ehit = 1; eaddr = AW'(idx); end
        else if (m_count() == NE) eerr = 1;
        else begin
          j = 0;
          while (m_used[j]) j++;
          eaddr = AW'(j); epulse = 1;
          m_used[j] = 1; m_key[j] = key;
        end
      end
      2'b10: begin
        if (idx >= 0) begin ehit = 1; eaddr = AW'(idx); epulse = 1; edel = 1; m_used[idx] = 0; end
        else eerr = 1;
      end
      default: eerr = 1;
    endcase
    p0 = pulses;
    do_cmd(op, key, rdy_delay, hit, addr, err, ok, stable);
    check("handshake", 64'(ok), 64'd1);
    check("rsp_hit", 64'(hit), 64'(ehit));
    check("rsp_addr", 64'(addr), 64'(eaddr));
    check("rsp_err", 64'(err), 64'(eerr));
    check("write_pulses", 64'(pulses - p0), 64'(epulse));
    check("occupancy", 64'(occupancy), 64'(m_count()));
    if (epulse == 1) begin
      check("pulse_addr", 64'(pulse_addr), 64'(eaddr));
      check("pulse_delete", 64'(pulse_del), 64'(edel));
    end
    if (rdy_delay > 0) check("rsp_stable", 64'(stable), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_clear();
  endtask

  initial begin
    bit seen_ready;
    int n, r, p0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_mask = '1;
    rsp_ready = 1'b0; cam_setup = 1'b1;
    m_clear();
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_occupancy", 64'(occupancy), 64'd0);
    check("reset_wr_en", 64'(cam_write_enable), 64'd0);
    rst = 1'b0;

    // CAM initialising: no command may be accepted.
    seen_ready = 0;
    repeat (10) begin @(negedge clk); if (cmd_ready) seen_ready = 1; end
    check("ready_during_setup", 64'(seen_ready), 64'd0);
    cam_setup = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_setup", 64'(cmd_ready), 64'd1);

    run_cmd(2'b00, 64'hDEAD, 0);
    run_cmd(2'b01, 64'h11, 0);
    run_cmd(2'b01, 64'h22, 0);
    run_cmd(2'b01, 64'h33, 0);
    run_cmd(2'b01, 64'h22, 0);
    run_cmd(2'b10, 64'h22, 0);
    run_cmd(2'b01, 64'h44, 0);
    run_cmd(2'b10, 64'h99, 0);
    run_cmd(2'b11, 64'h11, 0);

    // Random mix over a small key pool to force hits, misses and reuse.
    for (int k = 0; k < 150; k++) begin
      busy_len = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      run_cmd(r < 3 ? 2'b00 : r < 7 ? 2'b01 : r < 9 ? 2'b10 : 2'b11,
              64'($urandom_range(1, 40)), $urandom_range(0, 2));
    end

    // Long CAM busy and a stalled response.
    busy_len = 5;
    run_cmd(2'b01, 64'hABCD_0001, 3);
    busy_len = 0;

    // Fill every slot, then one more insert must be refused.
    for (int k = 0; m_count() < NE && k < 64; k++) run_cmd(2'b01, 64'h1000 + 64'(k), 0);
    check("table_full", 64'(occupancy), 64'(NE));
    run_cmd(2'b01, 64'hBEEF_BEEF, 0);
    run_cmd(2'b00, 64'h1005, 1);

    // Reset while waiting on CAM busy: command is dropped without a response.
    busy_len = 8;
    p0 = pulses;
    cmd_op = 2'b10; cmd_data = m_key[3]; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (pulses == p0 && n < 200) begin @(negedge clk); n++; end
    check("abort_pulse_seen", 64'(pulses - p0), 64'd1);
    busy_len = 0;
    do_reset();
    seen_ready = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (rsp_valid) seen_ready = 1; end
    check("abort_no_rsp", 64'(seen_ready), 64'd0);
    check("abort_occupancy", 64'(occupancy), 64'd0);
    check("abort_ready_back", 64'(cmd_ready), 64'd1);
    run_cmd(2'b01, 64'h77, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
